// File: rtl/uart_pkg.sv
// Types and constants shared by the UART-side indicator logic (pulse stretcher,
// debouncer top-level defaults).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  localparam int unsigned DEF_ON_CYCLES  = 25_000_000;
  localparam int unsigned DEF_OFF_CYCLES = 12_500_000;

  // Timer must hold max(on, off) - 1; never let the width collapse to zero.
  function automatic int unsigned timer_width(input int unsigned on_c,
                                              input int unsigned off_c);
    int unsigned m;
    m = (on_c > off_c) ? on_c : off_c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_stretcher_cycle_timer.sv
// Free-running up-counter with synchronous load-to-zero and an equality
// terminal flag against a caller-supplied compare value.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] cmp,
  output logic             terminal
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (load) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign terminal = (cnt_q == cmp);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into visible LED pulses: ON_CYCLES high, then at
// least OFF_CYCLES low, with a saturating queue of events that arrive meanwhile.
module pulse_stretcher
  import uart_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int unsigned PEND_MAX   = 7,
  parameter int unsigned RETRIGGER  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trig,
  input  logic                          clear,
  output logic                          led_out,
  output logic                          busy,
  output logic [$clog2(PEND_MAX+1)-1:0] pending,
  output logic                          overflow,
  output logic [1:0]                    state_dbg
);

  localparam int unsigned TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam int unsigned PW = $clog2(PEND_MAX + 1);

  localparam logic [TW-1:0] ON_LAST   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  stretch_state_t state_q, state_d;
  logic [PW-1:0]  pending_q, pending_d;
  logic           overflow_q, overflow_d;
  logic           timer_load;
  logic           timer_term;
  logic           pend_inc;
  logic [TW-1:0]  timer_cmp;

  assign timer_cmp = (state_q == ON) ? ON_LAST : OFF_LAST;

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .cmp      (timer_cmp),
    .terminal (timer_term)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    timer_load = 1'b0;
    pend_inc   = 1'b0;
    if (clear) begin
      state_d    = IDLE;
      pending_d  = '0;
      overflow_d = 1'b0;
      timer_load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          timer_load = 1'b1;
          if (trig) state_d = ON;
        end
        ON: begin
          if (trig && (RETRIGGER != 0)) begin
            timer_load = 1'b1;
          end else if (timer_term) begin
            state_d    = GAP;
            timer_load = 1'b1;
          end
          if (trig && (RETRIGGER == 0)) pend_inc = 1'b1;
        end
        GAP: begin
          if (timer_term) begin
            timer_load = 1'b1;
            // A trig on the terminal cycle is queued and consumed at once, so
            // it never touches pending or overflow.
            if ((pending_q != '0) || trig) begin
              state_d = ON;
              if (!trig) pending_d = pending_q - 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (trig) begin
            pend_inc = 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          timer_load = 1'b1;
        end
      endcase
      if (pend_inc) begin
        if (pending_q == PEND_FULL) overflow_d = 1'b1;
        else                        pending_d  = pending_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign led_out   = (state_q == ON);
  assign busy      = (state_q != IDLE);
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: one instance per RETRIGGER setting, shared stimulus,
// an event-count model checked every cycle, plus literal per-scenario checks.
module tb_pulse_stretcher;
  import uart_pkg::*;

  localparam int ON_C  = 4;
  localparam int OFF_C = 2;
  localparam int PMAX  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic clear = 1'b0;
  int   cyc = 0;
  int   base = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       led0, busy0, ovf0, led1, busy1, ovf1;
  logic [1:0] pend0, pend1, st0, st1;

  pulse_stretcher #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .PEND_MAX(PMAX), .RETRIGGER(0)) u0 (
    .clk(clk), .rst(rst), .trig(trig), .clear(clear), .led_out(led0), .busy(busy0),
    .pending(pend0), .overflow(ovf0), .state_dbg(st0));

  pulse_stretcher #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .PEND_MAX(PMAX), .RETRIGGER(1)) u1 (
    .clk(clk), .rst(rst), .trig(trig), .clear(clear), .led_out(led1), .busy(busy1),
    .pending(pend1), .overflow(ovf1), .state_dbg(st1));

  // scoreboard counters and check helper
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc - base, act, exp);
    end
  endtask

  // model: cycles of light left, cycles of gap left, queued events
  typedef struct {
    int on_left;
    int gap_left;
    int pend;
    bit ovf;
  } model_t;

  model_t m0 = '{0, 0, 0, 1'b0};
  model_t m1 = '{0, 0, 0, 1'b0};

  function automatic model_t queue_event(input model_t m);
    model_t n = m;
    if (n.pend == PMAX) n.ovf = 1'b1;
    else                n.pend = n.pend + 1;
    return n;
  endfunction

  function automatic model_t step(input model_t m, input bit r, input bit c,
                                  input bit t, input bit ret);
    model_t n = m;
    if (r || c) begin
      n = '{0, 0, 0, 1'b0};
    end else if (m.on_left > 0) begin
      if (ret && t) begin
        n.on_left = ON_C;
      end else begin
        n.on_left = m.on_left - 1;
        if (n.on_left == 0) n.gap_left = OFF_C;
        if (t) n = queue_event(n);
      end
    end else if (m.gap_left > 0) begin
      n.gap_left = m.gap_left - 1;
      if (m.gap_left == 1) begin
        if (m.pend > 0 || t) begin
          n.on_left = ON_C;
          n.pend    = m.pend + (t ? 1 : 0) - 1;
        end
      end else if (t) begin
        n = queue_event(n);
      end
    end else if (t) begin
      n.on_left = ON_C;
    end
    return n;
  endfunction

  // compare process: every cycle after the first reset edge
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("u0_led",      led0,  m0.on_left > 0);
      chk("u0_busy",     busy0, (m0.on_left > 0) || (m0.gap_left > 0));
      chk("u0_pending",  pend0, m0.pend);
      chk("u0_overflow", ovf0,  m0.ovf);
      chk("u1_led",      led1,  m1.on_left > 0);
      chk("u1_busy",     busy1, (m1.on_left > 0) || (m1.gap_left > 0));
      chk("u1_pending",  pend1, m1.pend);
      chk("u1_overflow", ovf1,  m1.ovf);
    end
    m0 = step(m0, rst, clear, trig, 1'b0);
    m1 = step(m1, rst, clear, trig, 1'b1);
  end

  // per-cycle history of the current scenario
  logic       led0_h[64], busy0_h[64], ovf0_h[64], led1_h[64], busy1_h[64];
  logic [1:0] pend0_h[64], pend1_h[64], st0_h[64];

  // driver tasks
  task automatic at_cycle(input int n);
    while (cyc != base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_scn(input bit trig_in_rst);
    @(posedge clk);
    #1;
    rst = 1'b1; clear = 1'b0; trig = trig_in_rst;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0; trig = 1'b0;
    base = cyc;
  endtask

  task automatic play(input logic [63:0] tmask, input logic [63:0] cmask, input int upto);
    for (int n = 0; n <= upto; n++) begin
      at_cycle(n);
      trig  = tmask[n];
      clear = cmask[n];
      @(negedge clk);
      led0_h[n] = led0; busy0_h[n] = busy0; pend0_h[n] = pend0; ovf0_h[n] = ovf0;
      st0_h[n] = st0; led1_h[n] = led1; busy1_h[n] = busy1; pend1_h[n] = pend1;
    end
  endtask

  function automatic logic [63:0] bits(input int a, input int b);
    logic [63:0] v = '0;
    for (int i = a; i <= b; i++) v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit, compared %0d", $time, n_cmp);
    $fatal(1);
  end

  initial begin
    int ons;

    // reset with trig held high: nothing may start
    begin_scn(1'b1);
    play('0, '0, 4);
    chk("rst_led", led0_h[0], 0);
    chk("rst_busy", busy0_h[0], 0);
    chk("rst_pending", pend0_h[0], 0);
    chk("rst_overflow", ovf0_h[0], 0);
    chk("rst_no_pulse", busy0_h[3] | busy1_h[3], 0);

    // single event
    begin_scn(1'b0);
    play(bits(10, 10), '0, 18);
    chk("single_led10", led0_h[10], 0);
    chk("single_led11", led0_h[11], 1);
    chk("single_led14", led0_h[14], 1);
    chk("single_led15", led0_h[15], 0);
    chk("single_busy16", busy0_h[16], 1);
    chk("single_busy17", busy0_h[17], 0);

    // queued event
    begin_scn(1'b0);
    play(bits(10, 10) | bits(12, 12), '0, 25);
    chk("queue_pend13", pend0_h[13], 1);
    chk("queue_led16", led0_h[16], 0);
    chk("queue_led17", led0_h[17], 1);
    chk("queue_pend17", pend0_h[17], 0);
    chk("queue_led20", led0_h[20], 1);
    chk("queue_busy22", busy0_h[22], 1);
    chk("queue_busy23", busy0_h[23], 0);

    // saturation, then clear drops the sticky overflow
    begin_scn(1'b0);
    play(bits(10, 15), bits(41, 41), 44);
    chk("sat_pend15", pend0_h[15], 3);
    chk("sat_ovf15", ovf0_h[15], 1);
    ons = 0;
    for (int n = 11; n <= 40; n++) if (led0_h[n] && !led0_h[n-1]) ons++;
    chk("sat_on_periods", ons, 4);
    chk("sat_ovf40", ovf0_h[40], 1);
    chk("sat_ovf42", ovf0_h[42], 0);

    // retrigger mid-pulse (u1), same stimulus queues on u0
    begin_scn(1'b0);
    play(bits(10, 10) | bits(13, 13), '0, 24);
    chk("retrig_led11", led1_h[11], 1);
    chk("retrig_led17", led1_h[17], 1);
    chk("retrig_led18", led1_h[18], 0);
    chk("retrig_busy19", busy1_h[19], 1);
    chk("retrig_busy20", busy1_h[20], 0);
    chk("retrig_pend14", pend1_h[14], 0);

    // trig on the ON terminal cycle
    begin_scn(1'b0);
    play(bits(10, 10) | bits(14, 14), '0, 26);
    chk("retrig_term_led18", led1_h[18], 1);
    chk("retrig_term_led19", led1_h[19], 0);
    chk("on_term_pend15", pend0_h[15], 1);
    chk("on_term_led17", led0_h[17], 1);

    // trig on the GAP terminal cycle with an empty queue
    begin_scn(1'b0);
    play(bits(10, 10) | bits(16, 16), '0, 24);
    chk("gap_term_led17", led0_h[17], 1);
    chk("gap_term_pend17", pend0_h[17], 0);

    // full queue plus trig on the GAP terminal cycle: nothing lost
    begin_scn(1'b0);
    play(bits(10, 13) | bits(16, 16), '0, 40);
    chk("satc_pend14", pend0_h[14], 3);
    chk("satc_led17", led0_h[17], 1);
    chk("satc_pend17", pend0_h[17], 3);
    chk("satc_ovf17", ovf0_h[17], 0);

    // abort with clear, trig in the same cycle discarded
    begin_scn(1'b0);
    play(bits(10, 10) | bits(12, 12) | bits(15, 15), bits(12, 12), 22);
    chk("abort_led13", led0_h[13], 0);
    chk("abort_pend13", pend0_h[13], 0);
    chk("abort_busy13", busy0_h[13], 0);
    chk("abort_state13", st0_h[13], IDLE);
    chk("abort_led16", led0_h[16], 1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
